// File: rtl/stream_arbiter_4.sv
`default_nettype none
// ============================================================================
// stream_arbiter_4 : packet-aware round-robin merge of four stb/ack streams
// Rev 1.0
// ============================================================================
module stream_arbiter_4 #(
    parameter int unsigned      WIDTH      = 32,
    parameter bit               EOM_ENABLE = 1'b1,
    parameter logic [WIDTH-1:0] EOM_VALUE  = 'h0000000A,
    parameter int unsigned      MAX_BURST  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] input_in0,
    input  logic [WIDTH-1:0] input_in1,
    input  logic [WIDTH-1:0] input_in2,
    input  logic [WIDTH-1:0] input_in3,
    input  logic             input_in0_stb,
    input  logic             input_in1_stb,
    input  logic             input_in2_stb,
    input  logic             input_in3_stb,
    output logic             input_in0_ack,
    output logic             input_in1_ack,
    output logic             input_in2_ack,
    output logic             input_in3_ack,
    output logic [WIDTH-1:0] output_out,
    output logic             output_out_stb,
    input  logic             output_out_ack,
    output logic [1:0]       grant,
    output logic             busy
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [15:0] C_MAX_BURST = 16'(MAX_BURST);

    state_t           state_q;
    logic [1:0]       grant_q;
    logic [15:0]      cnt_q;
    logic [15:0]      cnt_d;
    logic [WIDTH-1:0] out_q;
    logic             out_stb_q;
    logic             busy_q;

    logic [3:0]       w_stb;
    logic [WIDTH-1:0] w_data [4];
    logic [WIDTH-1:0] w_sel_data;
    logic             w_load_ok;
    logic             w_xfer;
    logic [3:0]       w_ack;
    logic             w_rr_hit;
    logic [1:0]       w_rr_idx;
    logic             w_eom;
    logic             w_burst_end;

    assign w_stb = {input_in3_stb, input_in2_stb, input_in1_stb, input_in0_stb};

    always_comb begin
        w_data[0] = input_in0;
        w_data[1] = input_in1;
        w_data[2] = input_in2;
        w_data[3] = input_in3;
    end

    assign w_sel_data = w_data[grant_q];
    assign w_load_ok  = !out_stb_q || output_out_ack;
    assign w_xfer     = (state_q == LOCKED) && w_stb[grant_q] && w_load_ok;
    assign w_ack      = w_xfer ? (4'b0001 << grant_q) : 4'b0000;

    // Scan from grant+4 (the last grantee) down to grant+1 so the nearest hit wins.
    always_comb begin
        w_rr_hit = 1'b0;
        w_rr_idx = grant_q;
        for (int i = 4; i >= 1; i--) begin
            if (w_stb[grant_q + 2'(i)]) begin
                w_rr_hit = 1'b1;
                w_rr_idx = grant_q + 2'(i);
            end
        end
    end

    assign cnt_d       = cnt_q + 16'd1;
    assign w_eom       = EOM_ENABLE && (w_sel_data == EOM_VALUE);
    assign w_burst_end = (MAX_BURST != 0) && (cnt_d == C_MAX_BURST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            grant_q   <= 2'd3;
            cnt_q     <= 16'd0;
            out_q     <= '0;
            out_stb_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            if (w_xfer) begin
                out_q     <= w_sel_data;
                out_stb_q <= 1'b1;
            end else if (output_out_ack) begin
                out_stb_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (w_rr_hit) begin
                        grant_q <= w_rr_idx;
                        cnt_q   <= 16'd0;
                        state_q <= LOCKED;
                        busy_q  <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (w_xfer) begin
                        cnt_q <= cnt_d;
                        if (w_eom || w_burst_end) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign input_in0_ack  = w_ack[0];
    assign input_in1_ack  = w_ack[1];
    assign input_in2_ack  = w_ack[2];
    assign input_in3_ack  = w_ack[3];
    assign output_out     = out_q;
    assign output_out_stb = out_stb_q;
    assign grant          = grant_q;
    assign busy           = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_arbiter_4.sv
`default_nettype none
// ============================================================================
// tb_stream_arbiter_4 : directed scenarios plus randomized traffic vs a model
// Rev 1.0
// ============================================================================
module tb_stream_arbiter_4;

    localparam bit          EOM_EN = 1'b1;
    localparam logic [31:0] EOMV   = 32'h0000000A;
    localparam int          MB     = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in_data [4];
    logic [3:0]  in_stb;
    logic [3:0]  in_ack;
    logic [31:0] out_data;
    logic        out_stb;
    logic        out_ack;
    logic [1:0]  grant;
    logic        busy;

    always #5 clk = ~clk;

    stream_arbiter_4 #(
        .WIDTH(32), .EOM_ENABLE(EOM_EN), .EOM_VALUE(EOMV), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .rst(rst),
        .input_in0(in_data[0]), .input_in1(in_data[1]),
        .input_in2(in_data[2]), .input_in3(in_data[3]),
        .input_in0_stb(in_stb[0]), .input_in1_stb(in_stb[1]),
        .input_in2_stb(in_stb[2]), .input_in3_stb(in_stb[3]),
        .input_in0_ack(in_ack[0]), .input_in1_ack(in_ack[1]),
        .input_in2_ack(in_ack[2]), .input_in3_ack(in_ack[3]),
        .output_out(out_data), .output_out_stb(out_stb), .output_out_ack(out_ack),
        .grant(grant), .busy(busy)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Stimulus staged between edges, applied to the ports at the falling edge.
    logic [31:0] s_data [4];
    logic [3:0]  s_stb;
    logic        s_sink;
    logic [3:0]  last_ack;

    // Reference: arbitration state as described at message level.
    bit          m_locked;
    int          m_grant;
    int          m_cnt;
    logic [31:0] m_out;
    bit          m_stb;

    logic [31:0] out_log [$];
    logic [31:0] ex [$];
    logic [31:0] dq [4][$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_grant  = 3;
        m_cnt    = 0;
        m_out    = '0;
        m_stb    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("rst_out_stb", {31'd0, out_stb}, 32'd0);
        check_eq("rst_out", out_data, 32'd0);
        check_eq("rst_ack", {28'd0, in_ack}, 32'd0);
        check_eq("rst_grant", {30'd0, grant}, 32'd3);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        model_reset();
        last_ack = '0;
    endtask

    task automatic cycle();
        logic [3:0] e_ack;
        bit         lok;
        bit         xf;
        int         f;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) in_data[k] = s_data[k];
        in_stb  = s_stb;
        out_ack = s_sink;
        #1;
        lok   = !m_stb || out_ack;
        xf    = m_locked && in_stb[m_grant] && lok;
        e_ack = xf ? 4'(1 << m_grant) : 4'b0000;
        check_eq("ack", {28'd0, in_ack}, {28'd0, e_ack});
        check_eq("out_stb", {31'd0, out_stb}, {31'd0, m_stb});
        check_eq("out_data", out_data, m_out);
        check_eq("busy", {31'd0, busy}, {31'd0, m_locked});
        check_eq("grant", {30'd0, grant}, 32'(m_grant));
        last_ack = in_ack;
        if (out_stb && out_ack) out_log.push_back(out_data);
        @(posedge clk);
        if (xf) begin
            m_out = in_data[m_grant];
            m_stb = 1'b1;
        end else if (out_ack) begin
            m_stb = 1'b0;
        end
        if (!m_locked) begin
            f = -1;
            for (int i = 1; i <= 4; i++)
                if (f < 0 && in_stb[(m_grant + i) % 4]) f = (m_grant + i) % 4;
            if (f >= 0) begin
                m_grant  = f;
                m_cnt    = 0;
                m_locked = 1'b1;
            end
        end else if (xf) begin
            m_cnt = (m_cnt + 1) % 65536;
            if ((EOM_EN && in_data[m_grant] == EOMV) || (MB != 0 && m_cnt == MB))
                m_locked = 1'b0;
        end
    endtask

    task automatic run_dir(input int ncyc, input int st_from, input int st_len);
        out_log.delete();
        for (int c = 0; c < ncyc; c++) begin
            for (int k = 0; k < 4; k++) begin
                s_stb[k]  = (dq[k].size() > 0);
                s_data[k] = (dq[k].size() > 0) ? dq[k][0] : 32'd0;
            end
            s_sink = !(c >= st_from && c < st_from + st_len);
            cycle();
            for (int k = 0; k < 4; k++)
                if (last_ack[k] && dq[k].size() > 0) void'(dq[k].pop_front());
        end
    endtask

    task automatic check_log(input string tag);
        check_eq({tag, "_len"}, 32'(out_log.size()), 32'(ex.size()));
        for (int i = 0; i < ex.size(); i++)
            check_eq(tag, (i < out_log.size()) ? out_log[i] : 32'hxxxxxxxx, ex[i]);
    endtask

    function automatic logic [31:0] newword();
        return ($urandom_range(3) == 0) ? EOMV : 32'($urandom);
    endfunction

    initial begin
        bit want_rst;
        for (int k = 0; k < 4; k++) begin
            in_data[k] = '0;
            s_data[k]  = '0;
        end
        in_stb   = '0;
        s_stb    = '0;
        out_ack  = 1'b0;
        s_sink   = 1'b1;
        last_ack = '0;
        model_reset();

        // Single stream, sink always ready.
        do_reset();
        dq[2] = {32'h48, 32'h69, 32'h0A};
        run_dir(20, 0, 0);
        ex = {32'h48, 32'h69, 32'h0A};
        check_log("t1_seq");
        #1;
        check_eq("t1_busy", {31'd0, busy}, 32'd0);
        check_eq("t1_grant", {30'd0, grant}, 32'd2);

        // Four-way contention right after reset.
        do_reset();
        for (int k = 0; k < 4; k++) dq[k] = {32'h0A};
        run_dir(20, 0, 0);
        ex = {32'h0A, 32'h0A, 32'h0A, 32'h0A};
        check_log("t2_seq");

        // No interleave across a message.
        do_reset();
        dq[0] = {32'h41, 32'h42, 32'h0A};
        dq[1] = {32'h78};
        run_dir(20, 0, 0);
        ex = {32'h41, 32'h42, 32'h0A, 32'h78};
        check_log("t3_seq");

        // Burst limit of 4 against a second requester.
        do_reset();
        dq[1] = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10};
        dq[3] = {32'h0A};
        run_dir(40, 0, 0);
        ex = {32'd1, 32'd2, 32'd3, 32'd4, 32'h0A, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10};
        check_log("t4_seq");

        // Sink stalls for 5 cycles mid-packet.
        do_reset();
        dq[0] = {32'h41, 32'h42, 32'h43, 32'h0A};
        run_dir(30, 3, 5);
        ex = {32'h41, 32'h42, 32'h43, 32'h0A};
        check_log("t5_seq");

        // Randomized traffic with occasional asynchronous reset mid-packet.
        do_reset();
        s_stb    = '0;
        want_rst = 1'b0;
        for (int it = 0; it < 3000; it++) begin
            for (int k = 0; k < 4; k++) begin
                if (s_stb[k] && last_ack[k]) begin
                    if ($urandom_range(99) < 70) s_data[k] = newword();
                    else s_stb[k] = 1'b0;
                end else if (!s_stb[k] && $urandom_range(99) < 20) begin
                    s_stb[k]  = 1'b1;
                    s_data[k] = newword();
                end
            end
            s_sink = ($urandom_range(99) < 70);
            if (it % 500 == 499) want_rst = 1'b1;
            if (want_rst && m_stb) begin
                do_reset();
                want_rst = 1'b0;
            end
            cycle();
        end

        // A fresh packet after a reset passes intact, in0 first.
        do_reset();
        for (int k = 0; k < 4; k++) dq[k].delete();
        dq[0] = {32'h11, 32'h0A};
        dq[3] = {32'h33, 32'h0A};
        run_dir(20, 0, 0);
        ex = {32'h11, 32'h0A, 32'h33, 32'h0A};
        check_log("t6_seq");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
